bcd_stopwatch: RTL and testbench
================================

// Module: bcd_stopwatch
// PURPOSE
//   Parametrised multi-digit BCD timer for the board top level. Divides fastclock down to a tick
//   rate and counts NUM_DIGITS cascaded decimal digits up (stopwatch) or down (countdown).
//   Supports run/pause control, preset load, wrap and terminal-count flags.
//   Drives one active-low 7-segment display per digit.
// PARAMETERS
//   CLK_HZ      50_000_000  fastclock frequency in Hz
//   TICK_HZ     1           count rate in Hz; DIV = CLK_HZ/TICK_HZ, DIV >= 2
//   NUM_DIGITS  4           number of BCD digits, 1..8; digit 0 is least significant
// PORTS
//   fastclock   in   1             system clock; all state changes on its rising edge
//   resetn      in   1             reset, synchronous, active-low
//   clear       in   1             pulse: value <= 0, state <= IDLE
//   load        in   1             pulse: value <= load_value, state <= IDLE
//   load_value  in   4*NUM_DIGITS  BCD preset; any nibble > 9 is loaded as 9
//   start       in   1             pulse: begin/resume counting
//   stop        in   1             pulse: pause counting
//   down        in   1             0 = count up, 1 = count down; sampled on every tick
//   digits      out  4*NUM_DIGITS  current BCD value
//   seg         out  7*NUM_DIGITS  active-low segments {g..a} per digit; digit i = seg[7i+6:7i]
//   tick        out  1             1-cycle pulse: count-update cycle
//   wrap        out  1             1-cycle pulse: up-count rolled all-9s -> 0
//   done        out  1             level: countdown reached 0 (state DONE)
//   running     out  1             level: state == RUN
// BEHAVIOUR
//   - Reset (resetn=0 at posedge): state IDLE, prescaler 0, digits 0, tick/wrap/done/running 0,
//     seg shows "0" on every digit.
//   - Control priority, highest first: resetn > clear > load > stop > start.
//   - FSM states: IDLE, RUN, PAUSED, DONE.
//       IDLE   -- start --> RUN
//       RUN    -- stop --> PAUSED
//       RUN    -- down tick at value 0 --> DONE
//       PAUSED -- start --> RUN
//       DONE   -- start is ignored; only clear, load or reset leave DONE (to IDLE)
//     start and stop asserted in the same cycle: stop wins.
//   - Prescaler: 0..DIV-1, counts only in RUN, held (not cleared) in PAUSED, cleared by
//     reset/clear/load.
//   - tick = (state==RUN) && (prescaler==DIV-1), combinational.
//     digits/wrap/done update on the same edge, so the first tick comes DIV cycles after start.
//   - Up tick: digit 0 increments. A digit at 9 goes to 0 and carries to the next digit.
//     All digits at 9 -> all 0, with wrap=1 for exactly one cycle (registered) after that edge.
//   - Down tick: digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit.
//     Value already 0 on a down tick -> digits stay 0, state DONE, done=1.
//   - running and done are decoded from state. seg is combinational from digits.
//     Encoding 0-9 standard; codes >9 cannot occur, and blank (7'h7F) is emitted if they do.
//   - Toggling down mid-run applies at the next tick; prescaler phase is kept.
//   - clear/load in any state, including mid-run, take effect at that edge.
//     No tick is issued in that cycle.
// STRUCTURE
//   - Shared package: FSM state encodings (2-bit), 7-seg pattern constants for 0-9 and blank,
//     DIV computation function.
//   - Sub-module bcd_digit:
//       inputs  inc, dec, clr, ld, ld_val[3:0]
//       outputs q[3:0], carry (q==9 & inc), borrow (q==0 & dec)
//     Instantiate NUM_DIGITS times in a generate loop.
//     Digit i+1 inc/dec = digit i carry/borrow.
//   - Prescaler, FSM and flag registers live in bcd_stopwatch.
//   - 7-seg decode: function in the package.
// TESTING  (CLK_HZ=10, TICK_HZ=1 -> DIV=10, NUM_DIGITS=2 unless stated)
//   1. Reset, then start pulse, down=0, run 35 cycles
//      -> tick at cycles 10/20/30 after start; digits 8'h03; running=1.
//   2. load_value=8'h98, load, start, down=0, run 2 ticks
//      -> 8'h99 then 8'h00 with wrap=1 for exactly 1 cycle; counting continues.
//   3. load_value=8'h02, load, start, down=1, 3 ticks
//      -> 8'h01, 8'h00, then done=1, running=0, digits stay 8'h00; a later start is ignored.
//   4. start, 5 cycles, stop, wait 50, start
//      -> no tick while PAUSED; first tick 5 cycles after resume; digits 8'h01.
//   5. start+stop in same cycle from IDLE -> stays IDLE.
//      clear during RUN at prescaler=7 -> digits 0, IDLE, no tick.
//   6. load_value=8'hF3, load -> digits 8'h93, seg digit1=~7'h6F, digit0=~7'h4F.
//      resetn=0 mid-RUN -> all outputs at reset values next edge.

Source files
------------

// File: rtl/bcd_stopwatch_pkg.sv
// Shared definitions for the BCD stopwatch: FSM state encoding, 7-segment
// patterns and the prescaler divide helper.
package bcd_stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_BLANK_N = 7'h7F;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Returns the active-low pattern for one BCD digit
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return ~SEG_0;
      4'd1:    return ~SEG_1;
      4'd2:    return ~SEG_2;
      4'd3:    return ~SEG_3;
      4'd4:    return ~SEG_4;
      4'd5:    return ~SEG_5;
      4'd6:    return ~SEG_6;
      4'd7:    return ~SEG_7;
      4'd8:    return ~SEG_8;
      4'd9:    return ~SEG_9;
      default: return SEG_BLANK_N;
    endcase
  endfunction

endpackage

// File: rtl/bcd_stopwatch_digit.sv
// One cascadable decimal digit: clear, saturating preset load, increment with
// carry-out and decrement with borrow-out.
module bcd_digit (
  input  logic       fastclock,
  input  logic       resetn,
  input  logic       inc,
  input  logic       dec,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] q,
  output logic       carry,
  output logic       borrow
);

  logic [3:0] r_q;

  always_ff @(posedge fastclock) begin
    if (!resetn)     r_q <= 4'd0;
    else if (clr)    r_q <= 4'd0;
    else if (ld)     r_q <= (ld_val > 4'd9) ? 4'd9 : ld_val;
    else if (inc)    r_q <= (r_q == 4'd9) ? 4'd0 : r_q + 4'd1;
    else if (dec)    r_q <= (r_q == 4'd0) ? 4'd9 : r_q - 4'd1;
  end

  assign q      = r_q;
  assign carry  = inc & (r_q == 4'd9);
  assign borrow = dec & (r_q == 4'd0);

endmodule

// File: rtl/bcd_stopwatch.sv
// Multi-digit BCD up/down timer with run/pause control, preset load,
// wrap and terminal-count flags, and active-low 7-segment outputs.
module bcd_stopwatch
  import bcd_stopwatch_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    fastclock,
  input  logic                    resetn,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    down,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [7*NUM_DIGITS-1:0] seg,
  output logic                    tick,
  output logic                    wrap,
  output logic                    done,
  output logic                    running
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  state_t                  r_state;
  logic [PW-1:0]           r_presc;
  logic                    r_wrap;
  logic                    w_ctrl;
  logic                    w_tick;
  logic                    w_underflow;
  logic                    w_zero;
  logic [NUM_DIGITS:0]     w_carry;
  logic [NUM_DIGITS:0]     w_borrow;
  logic [4*NUM_DIGITS-1:0] w_digits;

  assign w_ctrl = clear | load;
  assign w_tick = (r_state == ST_RUN) && (r_presc == PRESC_LAST) && !w_ctrl;

  assign w_carry[0]  = w_tick & ~down;
  assign w_borrow[0] = w_tick & down;

  // A borrow out of the top digit means the value was already 0; the chain
  // would leave all 9s, so force every digit back to 0 on that edge.
  assign w_underflow = w_borrow[NUM_DIGITS];
  assign w_zero      = clear | w_underflow;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .fastclock (fastclock),
      .resetn    (resetn),
      .inc       (w_carry[g]),
      .dec       (w_borrow[g]),
      .clr       (w_zero),
      .ld        (load),
      .ld_val    (load_value[4*g +: 4]),
      .q         (w_digits[4*g +: 4]),
      .carry     (w_carry[g+1]),
      .borrow    (w_borrow[g+1])
    );
    assign seg[7*g +: 7] = seg_decode(w_digits[4*g +: 4]);
  end

  always_ff @(posedge fastclock) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_presc <= '0;
      r_wrap  <= 1'b0;
    end else if (w_ctrl) begin
      r_state <= ST_IDLE;
      r_presc <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= w_carry[NUM_DIGITS];
      if (r_state == ST_RUN)
        r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
      case (r_state)
        ST_IDLE, ST_PAUSED: if (start && !stop) r_state <= ST_RUN;
        ST_RUN: begin
          if (stop)             r_state <= ST_PAUSED;
          else if (w_underflow) r_state <= ST_DONE;
        end
        default: r_state <= r_state;
      endcase
    end
  end

  assign digits  = w_digits;
  assign tick    = w_tick;
  assign wrap    = r_wrap;
  assign done    = (r_state == ST_DONE);
  assign running = (r_state == ST_RUN);

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Scoreboard bench for bcd_stopwatch: directed scenarios plus random control
// traffic, checked every cycle against an integer-valued reference model.
module tb_bcd_stopwatch;

  localparam int CLK_HZ     = 10;
  localparam int TICK_HZ    = 1;
  localparam int NUM_DIGITS = 2;
  localparam int DIV        = CLK_HZ / TICK_HZ;
  localparam int MAXV       = 10 ** NUM_DIGITS - 1;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  logic                    fastclock = 1'b1;
  logic                    resetn, clear, load, start, stop, down;
  logic [4*NUM_DIGITS-1:0] load_value;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [7*NUM_DIGITS-1:0] seg;
  logic                    tick, wrap, done, running;

  bcd_stopwatch #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NUM_DIGITS(NUM_DIGITS)) dut (
    .fastclock  (fastclock),
    .resetn     (resetn),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .stop       (stop),
    .down       (down),
    .digits     (digits),
    .seg        (seg),
    .tick       (tick),
    .wrap       (wrap),
    .done       (done),
    .running    (running)
  );

  always #5 fastclock = ~fastclock;

  typedef struct {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [7*NUM_DIGITS-1:0] seg;
    logic tick, wrap, done, running;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0, failures = 0, cyc = 0;
  int   m_val = 0, m_presc = 0, m_state = M_IDLE;
  bit   m_wrap = 1'b0;
  bit   cur_down = 1'b0;

  function automatic logic [6:0] seg_low(input int d);
    logic [6:0] on;
    case (d)
      0: on = 7'h3F; 1: on = 7'h06; 2: on = 7'h5B; 3: on = 7'h4F; 4: on = 7'h66;
      5: on = 7'h6D; 6: on = 7'h7D; 7: on = 7'h07; 8: on = 7'h7F; default: on = 7'h6F;
    endcase
    return ~on;
  endfunction

  function automatic logic [4*NUM_DIGITS-1:0] to_bcd(input int v);
    logic [4*NUM_DIGITS-1:0] r;
    int p = 1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [7*NUM_DIGITS-1:0] to_seg(input int v);
    logic [7*NUM_DIGITS-1:0] r;
    int p = 1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r[7*i +: 7] = seg_low((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int from_load(input logic [4*NUM_DIGITS-1:0] lv);
    int v = 0, p = 1, n;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      n = int'(lv[4*i +: 4]);
      if (n > 9) n = 9;
      v = v + n * p;
      p = p * 10;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  // Issue one cycle of inputs, record what the DUT should show, advance the model
  task automatic step(input bit rn, input bit cl, input bit ld,
                      input logic [4*NUM_DIGITS-1:0] lv,
                      input bit st, input bit sp, input bit dn);
    exp_t e;
    bit   tk, under;
    resetn = rn; clear = cl; load = ld; load_value = lv;
    start = st; stop = sp; down = dn;
    tk = (m_state == M_RUN) && (m_presc == DIV - 1) && !cl && !ld;
    e.digits  = to_bcd(m_val);
    e.seg     = to_seg(m_val);
    e.tick    = tk;
    e.wrap    = m_wrap;
    e.done    = (m_state == M_DONE);
    e.running = (m_state == M_RUN);
    sb.push_back(e);
    under = 1'b0;
    if (!rn || cl || ld) begin
      m_val   = (!rn || cl) ? 0 : from_load(lv);
      m_state = M_IDLE;
      m_presc = 0;
      m_wrap  = 1'b0;
    end else begin
      m_wrap = 1'b0;
      if (tk) begin
        if (!dn) begin
          if (m_val == MAXV) begin m_val = 0; m_wrap = 1'b1; end
          else m_val = m_val + 1;
        end else if (m_val == 0) under = 1'b1;
        else m_val = m_val - 1;
      end
      if (m_state == M_RUN) m_presc = (m_presc + 1) % DIV;
      case (m_state)
        M_IDLE, M_PAUSED: if (st && !sp) m_state = M_RUN;
        M_RUN: if (sp) m_state = M_PAUSED; else if (under) m_state = M_DONE;
        default: ;
      endcase
    end
    @(posedge fastclock);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, '0, 0, 0, cur_down);
  endtask

  // Monitor: compare the DUT against the oldest expectation each falling edge
  initial begin
    forever begin
      @(negedge fastclock);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("digits",  32'(digits),  32'(mon_e.digits));
        chk("seg",     32'(seg),     32'(mon_e.seg));
        chk("tick",    32'(tick),    32'(mon_e.tick));
        chk("wrap",    32'(wrap),    32'(mon_e.wrap));
        chk("done",    32'(done),    32'(mon_e.done));
        chk("running", 32'(running), 32'(mon_e.running));
      end
    end
  end

  initial begin
    logic [4*NUM_DIGITS-1:0] lv;
    bit rn;
    resetn = 1'b0; clear = 1'b0; load = 1'b0; load_value = '0;
    start = 1'b0; stop = 1'b0; down = 1'b0;
    @(posedge fastclock);
    #1;
    step(0, 0, 0, '0, 0, 0, 0);
    step(0, 0, 0, '0, 0, 0, 0);
    chk("reset_digits", 32'(digits), 32'h0);
    chk("reset_seg", 32'(seg), 32'({~7'h3F, ~7'h3F}));

    // Count up from 0
    cur_down = 1'b0;
    step(1, 0, 0, '0, 1, 0, 0);
    idle(35);
    chk("t1_digits", 32'(digits), 32'h03);
    chk("t1_running", 32'(running), 32'h1);

    // Roll over 99 -> 00
    step(1, 0, 1, 8'h98, 0, 0, 0);
    step(1, 0, 0, '0, 1, 0, 0);
    idle(10);
    chk("t2_99", 32'(digits), 32'h99);
    idle(10);
    chk("t2_00", 32'(digits), 32'h00);
    chk("t2_wrap", 32'(wrap), 32'h1);
    idle(1);
    chk("t2_wrap_clr", 32'(wrap), 32'h0);

    // Countdown to done; start ignored afterwards
    cur_down = 1'b1;
    step(1, 0, 1, 8'h02, 0, 0, 1);
    step(1, 0, 0, '0, 1, 0, 1);
    idle(30);
    chk("t3_done", 32'(done), 32'h1);
    chk("t3_running", 32'(running), 32'h0);
    step(1, 0, 0, '0, 1, 0, 1);
    idle(15);
    chk("t3_stay_done", 32'(done), 32'h1);
    chk("t3_digits", 32'(digits), 32'h00);

    // Pause keeps prescaler phase
    cur_down = 1'b0;
    step(1, 1, 0, '0, 0, 0, 0);
    step(1, 0, 0, '0, 1, 0, 0);
    idle(4);
    step(1, 0, 0, '0, 0, 1, 0);
    idle(50);
    step(1, 0, 0, '0, 1, 0, 0);
    idle(4);
    chk("t4_before", 32'(digits), 32'h00);
    idle(1);
    chk("t4_after", 32'(digits), 32'h01);

    // start+stop from IDLE, clear mid-run
    step(1, 1, 0, '0, 0, 0, 0);
    step(1, 0, 0, '0, 1, 1, 0);
    chk("t5_idle", 32'(running), 32'h0);
    step(1, 0, 0, '0, 1, 0, 0);
    idle(7);
    step(1, 1, 0, '0, 0, 0, 0);
    chk("t5_clear_run", 32'(running), 32'h0);
    chk("t5_clear_dig", 32'(digits), 32'h00);
    step(1, 0, 0, '0, 1, 0, 0);
    idle(9);
    step(1, 1, 0, '0, 0, 0, 0);
    chk("t5_clear_tick", 32'(digits), 32'h00);

    // Saturating load and reset mid-run
    step(1, 0, 1, 8'hF3, 0, 0, 0);
    chk("t6_load", 32'(digits), 32'h93);
    chk("t6_seg", 32'(seg), 32'({~7'h6F, ~7'h4F}));
    step(1, 0, 0, '0, 1, 0, 0);
    idle(12);
    step(0, 0, 0, '0, 0, 0, 0);
    chk("t6_rst_dig", 32'(digits), 32'h00);
    chk("t6_rst_run", 32'(running), 32'h0);
    chk("t6_rst_seg", 32'(seg), 32'({~7'h3F, ~7'h3F}));

    // Random control traffic
    for (int i = 0; i < 3000; i++) begin
      rn = ($urandom_range(299) != 0);
      if ($urandom_range(49) == 0) cur_down = ~cur_down;
      lv = (4*NUM_DIGITS)'($urandom);
      step(rn, $urandom_range(39) == 0, $urandom_range(29) == 0, lv,
           $urandom_range(7) == 0, $urandom_range(14) == 0, cur_down);
    end

    idle(2);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
